tcam_host_ctrl: RTL

Host-side command sequencer for the 16-entry × 16-bit ternary CAM. It accepts rule-write and key-lookup commands on a valid/ready interface and drives the TCAM's write and read strobes in the correct order. It captures the TCAM's registered match result and returns it on a valid/ready response channel. It also keeps rule-occupancy and hit/miss statistics for the lookup path.

---
 rtl/tcam_pkg.sv | 19 +
 rtl/tcam_sat_cnt.sv | 33 +++
 rtl/tcam_host_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM host-side controller: command opcodes,
// sequencer states and default widths.
package tcam_pkg;

   localparam int TCAM_DW = 16;
   localparam int TCAM_AW = 4;

   localparam logic OP_WRITE  = 1'b0;
   localparam logic OP_LOOKUP = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_SEARCH  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

endpackage

// File: rtl/tcam_sat_cnt.sv
// CW-bit counter that sticks at all-ones; a clear takes priority over an increment.
module tcam_sat_cnt #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          inc_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tcam_host_ctrl.sv
// Sequences rule writes and key lookups onto the TCAM strobes, returns the
// registered match on a valid/ready response and keeps occupancy/hit/miss stats.
module tcam_host_ctrl
   import tcam_pkg::*;
#(
   parameter int DW = TCAM_DW,
   parameter int AW = TCAM_AW,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_data,
   input  logic [DW-1:0] cmd_mask,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_hit,
   output logic [DW-1:0] rsp_data,
   output logic          tcam_w_e,
   output logic          tcam_r_e,
   output logic [AW-1:0] tcam_addr,
   output logic [DW-1:0] tcam_data,
   output logic [DW-1:0] tcam_mask,
   input  logic          tcam_match,
   input  logic [DW-1:0] tcam_matched_num,
   input  logic          clear_stats,
   output logic [CW-1:0] hit_cnt,
   output logic [CW-1:0] miss_cnt,
   output logic [AW:0]   rule_cnt
);

   localparam int DEPTH = 2 ** AW;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   data_q;
   logic [DW-1:0]   mask_q;
   logic [DEPTH-1:0] valid_map_q;
   logic [AW:0]     rule_cnt_q;
   logic            rsp_hit_q;
   logic [DW-1:0]   rsp_data_q;
   logic            accept;
   logic            capture;

   // Strobes decode straight from the state so an async reset kills them at once.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      tcam_w_e  = 1'b0;
      tcam_r_e  = 1'b0;
      tcam_addr = '0;
      tcam_data = '0;
      tcam_mask = '0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = (cmd_op == OP_WRITE) ? ST_WRITE : ST_SEARCH;
            end
         end
         ST_WRITE: begin
            tcam_w_e  = 1'b1;
            tcam_addr = addr_q;
            tcam_data = data_q;
            tcam_mask = mask_q;
            state_d   = ST_IDLE;
         end
         ST_SEARCH: begin
            tcam_r_e  = 1'b1;
            tcam_data = data_q;
            state_d   = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign accept  = cmd_valid && cmd_ready;
   assign capture = (state_q == ST_CAPTURE);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         mask_q      <= '0;
         valid_map_q <= '0;
         rule_cnt_q  <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            mask_q <= cmd_mask;
         end
         // Occupancy counts distinct addresses; a rewrite only refreshes the TCAM.
         if (state_q == ST_WRITE) begin
            valid_map_q[addr_q] <= 1'b1;
            if (!valid_map_q[addr_q]) begin
               rule_cnt_q <= rule_cnt_q + (AW+1)'(1);
            end
         end
         if (capture) begin
            rsp_hit_q  <= tcam_match;
            rsp_data_q <= tcam_matched_num;
         end
      end
   end

   assign rsp_hit  = rsp_hit_q;
   assign rsp_data = rsp_data_q;
   assign rule_cnt = rule_cnt_q;

   tcam_sat_cnt #(.CW(CW)) u_hit_cnt (
      .clk   (clk),
      .rstN  (rstN),
      .inc_i (capture && tcam_match),
      .clr_i (clear_stats),
      .cnt_o (hit_cnt)
   );

   tcam_sat_cnt #(.CW(CW)) u_miss_cnt (
      .clk   (clk),
      .rstN  (rstN),
      .inc_i (capture && !tcam_match),
      .clr_i (clear_stats),
      .cnt_o (miss_cnt)
   );

endmodule
